if_id_queue: RTL
================

# if_id_queue

Parametrised, elastic successor to the single-entry IF/ID latch, sitting between instruction fetch and decode. Holds up to DEPTH fetched {instruction, PC+4} pairs in a circular buffer. Fetch can run ahead of a stalled decode stage without losing slots. Supports valid/ready handshaking, a global hold, and a single-cycle flush that squashes every buffered entry and presents a NOP to decode.

## Interface
Parameters:
- DATA_W, 32, instruction word width
- PC_W, 32, PC+4 width
- DEPTH, 4, entry count; power of two, ≥2
- NOP_WORD, 32'h0000_0000, instruction presented when empty or flushed

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-high reset
- flush  in  1  squash all entries (branch/jump mispredict)
- hold  in  1  freeze: no push, no pop (e.g. memory not hit)
- in_valid  in  1  fetch offers an entry
- in_ready  out  1  buffer can accept (count < DEPTH and !hold)
- imemload_in  in  DATA_W  fetched instruction
- pcp4_in  in  PC_W  fetched PC+4
- out_valid  out  1  head entry valid (count > 0)
- out_ready  in  1  decode consumes head
- imemload_out  out  DATA_W  head instruction, NOP_WORD when !out_valid
- pcp4_out  out  PC_W  head PC+4, 0 when !out_valid
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !hold & !flush.
- Push writes mem[wr_ptr], wr_ptr++ (mod DEPTH). Pop advances rd_ptr++ (mod DEPTH).
- count next = count + push − pop. Push and pop in the same cycle at count == DEPTH is impossible (in_ready low). At count == 0, pop is impossible (out_valid low).
- in_ready does not look ahead to a same-cycle pop. Full means stall for one cycle; this is a deliberate choice for timing.
- flush: next cycle count = 0, rd_ptr = wr_ptr = 0, outputs show NOP_WORD / 0. Flush overrides push, pop and hold in the same cycle, so the incoming entry is dropped.
- hold (without flush): pointers and count frozen, and the input is ignored because in_ready is low.
- Outputs are taken from registered storage via rd_ptr. No combinational path runs from imemload_in to imemload_out.
- Storage contents are not cleared by flush; only pointers and count reset. Output masking guarantees NOP_WORD.

## Timing
- Reset (RST high, async): count = 0, pointers = 0, out_valid = 0, imemload_out = NOP_WORD, pcp4_out = 0, in_ready = 1 on the first cycle after release if hold = 0.
- Latency: an entry pushed at edge N appears at the outputs after edge N (visible in cycle N+1) when the buffer was empty.
- Throughput: 1 entry/cycle sustained when 0 < count < DEPTH and both sides are active.
- Wrap-around: pointers wrap DEPTH−1 → 0 with no bubble.
- RST asserted mid-operation: all state clears immediately; in-flight entries are lost.
- flush + hold together: flush wins.

## Structure
- Add to cpu_types_pkg: typedef if_id_entry_t (struct {word_t imemload; word_t pcp4;}). Also add localparam IF_ID_DEPTH = 4 as the system-wide default.
- Add a matching interface if_id_queue_if.vh with modports for fetch, decode and tb.
- One natural sub-module: if_id_ptr, a parametrised mod-DEPTH pointer with inc and clr inputs, instantiated twice.
- Storage is an array of if_id_entry_t, flip-flop based; no RAM macro.

## Test plan
- Reset: assert RST mid-stream with count = 3 → outputs immediately NOP_WORD/0, count = 0, out_valid = 0.
- Fill/drain: push 0x2008_0001..0x2008_0004 with out_ready = 0 → count = 4, in_ready = 0. Then out_ready = 1 for 4 cycles → the words emerge in order, then out_valid = 0.
- Wrap: 10 back-to-back pushes with out_ready = 1 and DEPTH = 4 → output sequence matches input, count stays ≤ 1, no bubbles after the first.
- Flush with simultaneous push: count = 2, flush = 1, in_valid = 1 with 0xDEAD_BEEF → next cycle count = 0 and imemload_out = NOP_WORD. 0xDEAD_BEEF never appears.
- Hold: count = 2, hold = 1 for 3 cycles with in_valid = out_ready = 1 → count and head unchanged. Release → normal flow resumes.
- Full boundary: count = 4 with push and pop offered → pop occurs, push refused, count = 3. Next cycle the push is accepted.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared types and defaults for the elastic IF/ID queue.
package if_id_queue_pkg;
    localparam int WORD_W = 32;
    localparam int IF_ID_DEPTH = 4;
    typedef logic [WORD_W-1:0] word_t;
    typedef struct packed {
        word_t imemload;
        word_t pcp4;
    } if_id_entry_t;
endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode handshake bundle for the IF/ID queue.
interface if_id_queue_if #(
    parameter int DATA_W = 32,
    parameter int PC_W = 32,
    parameter int DEPTH = 4
);
    logic flush;
    logic hold;
    logic in_valid;
    logic in_ready;
    logic [DATA_W-1:0] imemload_in;
    logic [PC_W-1:0] pcp4_in;
    logic out_valid;
    logic out_ready;
    logic [DATA_W-1:0] imemload_out;
    logic [PC_W-1:0] pcp4_out;
    logic [$clog2(DEPTH+1)-1:0] count;
    modport slave (
        input flush, hold, in_valid, imemload_in, pcp4_in, out_ready,
        output in_ready, out_valid, imemload_out, pcp4_out, count
    );
    modport master (
        output flush, hold, in_valid, imemload_in, pcp4_in, out_ready,
        input in_ready, out_valid, imemload_out, pcp4_out, count
    );
    modport fetch (
        output in_valid, imemload_in, pcp4_in,
        input in_ready, flush, hold
    );
    modport decode (
        output out_ready,
        input out_valid, imemload_out, pcp4_out, flush, hold
    );
endinterface

// File: rtl/if_id_queue_ptr.sv
// if_id_queue_ptr: mod-DEPTH pointer; DEPTH is a power of two so it wraps naturally.
module if_id_queue_ptr #(
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic [$clog2(DEPTH)-1:0] ptr
);
    localparam int W = $clog2(DEPTH);
    always_ff @(posedge CLK or posedge RST)
        if (RST) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + W'(1);
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry circular buffer of {instruction, PC+4} between fetch and decode.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int PC_W = WORD_W,
    parameter int DEPTH = IF_ID_DEPTH,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input logic CLK,
    input logic RST,
    if_id_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    typedef struct packed {
        logic [DATA_W-1:0] imemload;
        logic [PC_W-1:0] pcp4;
    } entry_t;
    entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic push, pop;
    // in_ready ignores a same-cycle pop to keep the ready path short
    always_comb begin
        q.in_ready = (count < CW'(DEPTH)) && !q.hold;
        q.out_valid = count != '0;
        push = q.in_valid && q.in_ready && !q.flush;
        pop = q.out_valid && q.out_ready && !q.hold && !q.flush;
        q.imemload_out = q.out_valid ? mem[rd_ptr].imemload : NOP_WORD;
        q.pcp4_out = q.out_valid ? mem[rd_ptr].pcp4 : '0;
        q.count = count;
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) count <= '0;
        else if (q.flush) count <= '0;
        else count <= count + CW'(push) - CW'(pop);
    // storage is left stale on flush; output masking hides it
    always_ff @(posedge CLK)
        if (push) mem[wr_ptr] <= {q.imemload_in, q.pcp4_in};
    if_id_queue_ptr #(.DEPTH(DEPTH)) u_wr (.CLK(CLK), .RST(RST), .inc(push), .clr(q.flush), .ptr(wr_ptr));
    if_id_queue_ptr #(.DEPTH(DEPTH)) u_rd (.CLK(CLK), .RST(RST), .inc(pop), .clr(q.flush), .ptr(rd_ptr));
endmodule
